bresenham_line_engine: RTL

- Queued, back-pressured successor to the single-line Bresenham drawer.
- Accepts line commands (endpoints plus colour) through a valid/ready port into an internal FIFO of depth CMD_DEPTH.
- Rasterises each line one pixel per cycle and streams pixels, clipped to the framebuffer, on a valid/ready output with the line's colour.
- Sits between the geometry/projection stage and the framebuffer writer.

---
 rtl/bresenham_line_engine_if.sv | 31 +++
 rtl/bresenham_line_engine.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bresenham_line_engine_if.sv
// Command and pixel stream bundle for the line engine.
// master = command producer / pixel consumer; slave = the engine.
interface bresenham_line_engine_if #(
   parameter int unsigned COORD_WIDTH = 16,
   parameter int unsigned COLOR_WIDTH = 8
);
   logic                          cmd_valid;
   logic                          cmd_ready;
   logic signed [COORD_WIDTH-1:0] cmd_x0;
   logic signed [COORD_WIDTH-1:0] cmd_y0;
   logic signed [COORD_WIDTH-1:0] cmd_x1;
   logic signed [COORD_WIDTH-1:0] cmd_y1;
   logic [COLOR_WIDTH-1:0]        cmd_color;
   logic                          pix_valid;
   logic                          pix_ready;
   logic signed [COORD_WIDTH-1:0] pix_x;
   logic signed [COORD_WIDTH-1:0] pix_y;
   logic [COLOR_WIDTH-1:0]        pix_color;
   logic                          line_done;
   logic                          busy;

   modport master (
      output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, pix_ready,
      input  cmd_ready, pix_valid, pix_x, pix_y, pix_color, line_done, busy
   );

   modport slave (
      input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, pix_ready,
      output cmd_ready, pix_valid, pix_x, pix_y, pix_color, line_done, busy
   );
endinterface

// File: rtl/bresenham_line_engine.sv
// Queued Bresenham rasteriser: buffers line commands and streams clipped
// pixels one per cycle, ordered from the lower-y endpoint to the higher-y one.
module bresenham_line_engine #(
   parameter int unsigned COORD_WIDTH = 16,
   parameter int unsigned FB_WIDTH    = 320,
   parameter int unsigned FB_HEIGHT   = 180,
   parameter int unsigned COLOR_WIDTH = 8,
   parameter int unsigned CMD_DEPTH   = 4
) (
   input logic                    clk_in,
   input logic                    rst_in,
   bresenham_line_engine_if.slave bus
);

   localparam int unsigned EW  = COORD_WIDTH + 2;
   localparam int unsigned EW2 = EW + 1;
   localparam int unsigned PW  = $clog2(CMD_DEPTH);

   localparam logic signed [EW-1:0] FBW   = EW'(FB_WIDTH);
   localparam logic signed [EW-1:0] FBH   = EW'(FB_HEIGHT);
   localparam logic signed [EW-1:0] ONE   = EW'(1);
   localparam logic signed [EW-1:0] ZERO  = EW'(0);
   localparam logic [PW:0]          P_ONE = (PW+1)'(1);

   typedef struct packed {
      logic [COORD_WIDTH-1:0] x0;
      logic [COORD_WIDTH-1:0] y0;
      logic [COORD_WIDTH-1:0] x1;
      logic [COORD_WIDTH-1:0] y1;
      logic [COLOR_WIDTH-1:0] color;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

   // Command FIFO: extra pointer bit distinguishes full from empty
   cmd_t        mem [CMD_DEPTH];
   logic [PW:0] wr_ptr, rd_ptr;
   logic        full, empty, push, pop;
   cmd_t        cmd_in, head;

   assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign empty  = (wr_ptr == rd_ptr);
   assign push   = bus.cmd_valid && !full;
   assign cmd_in = '{x0: bus.cmd_x0, y0: bus.cmd_y0, x1: bus.cmd_x1,
                     y1: bus.cmd_y1, color: bus.cmd_color};
   assign head   = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk_in) begin
      if (push) mem[wr_ptr[PW-1:0]] <= cmd_in;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + P_ONE;
         if (pop)  rd_ptr <= rd_ptr + P_ONE;
      end
   end

   // Rasteriser state
   state_t                 state, state_nxt;
   logic signed [EW-1:0]   xa, ya, xb, yb, dx, dy, err, x, y;
   logic signed [EW-1:0]   xa_nxt, ya_nxt, xb_nxt, yb_nxt;
   logic signed [EW-1:0]   dx_nxt, dy_nxt, err_nxt, x_nxt, y_nxt;
   logic                   right, right_nxt;
   logic [COLOR_WIDTH-1:0] color, color_nxt;
   logic                   done_q, done_nxt;

   logic signed [EW-1:0]   hx0, hy0, hx1, hy1, diff_x;
   logic signed [EW2-1:0]  e2;
   logic                   swap, in_bounds, at_end, advance, step_x, step_y;

   assign in_bounds = !x[EW-1] && (x < FBW) && !y[EW-1] && (y < FBH);
   assign at_end    = (x == xb) && (y == yb);
   assign advance   = !in_bounds || bus.pix_ready;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state  <= IDLE;
         xa     <= '0;
         ya     <= '0;
         xb     <= '0;
         yb     <= '0;
         dx     <= '0;
         dy     <= '0;
         err    <= '0;
         x      <= '0;
         y      <= '0;
         right  <= 1'b0;
         color  <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         xa     <= xa_nxt;
         ya     <= ya_nxt;
         xb     <= xb_nxt;
         yb     <= yb_nxt;
         dx     <= dx_nxt;
         dy     <= dy_nxt;
         err    <= err_nxt;
         x      <= x_nxt;
         y      <= y_nxt;
         right  <= right_nxt;
         color  <= color_nxt;
         done_q <= done_nxt;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_nxt = state;
      xa_nxt    = xa;
      ya_nxt    = ya;
      xb_nxt    = xb;
      yb_nxt    = yb;
      dx_nxt    = dx;
      dy_nxt    = dy;
      err_nxt   = err;
      x_nxt     = x;
      y_nxt     = y;
      right_nxt = right;
      color_nxt = color;
      done_nxt  = 1'b0;
      pop       = 1'b0;
      hx0       = EW'($signed(head.x0));
      hy0       = EW'($signed(head.y0));
      hx1       = EW'($signed(head.x1));
      hy1       = EW'($signed(head.y1));
      swap      = (hy0 > hy1);
      diff_x    = xb - xa;
      e2        = {err, 1'b0};
      step_x    = (e2 >= EW2'(dy));
      step_y    = (e2 <= EW2'(dx));

      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               xa_nxt    = swap ? hx1 : hx0;
               ya_nxt    = swap ? hy1 : hy0;
               xb_nxt    = swap ? hx0 : hx1;
               yb_nxt    = swap ? hy0 : hy1;
               right_nxt = (swap ? hx1 : hx0) < (swap ? hx0 : hx1);
               color_nxt = head.color;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            dx_nxt    = diff_x[EW-1] ? -diff_x : diff_x;
            dy_nxt    = ya - yb;
            err_nxt   = (diff_x[EW-1] ? -diff_x : diff_x) + (ya - yb);
            x_nxt     = xa;
            y_nxt     = ya;
            state_nxt = DRAW;
         end
         DRAW: begin
            if (advance) begin
               if (at_end) begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  // Both steps use the same e2, so a diagonal adds dx+dy to err
                  err_nxt = err + (step_x ? dy : ZERO) + (step_y ? dx : ZERO);
                  if (step_x) x_nxt = right ? x + ONE : x - ONE;
                  if (step_y) y_nxt = y + ONE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.cmd_ready = !full;
   assign bus.pix_valid = (state == DRAW) && in_bounds;
   assign bus.pix_x     = x[COORD_WIDTH-1:0];
   assign bus.pix_y     = y[COORD_WIDTH-1:0];
   assign bus.pix_color = color;
   assign bus.line_done = done_q;
   assign bus.busy      = (state != IDLE) || !empty;

endmodule
